// File: rtl/cpu_defs.sv
// Shared CPU constants: fetch address map and the next-PC controller state encoding.
// Combinational only; no latency or flow control applies.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] PC_MAX   = 32'h0000_6FFC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } npc_state_e;

endpackage

// File: rtl/npc_ctrl.sv
// Next-PC select with a one-entry buffer for branches resolved during a fetch stall.
// next_pc is combinational; a buffered target is released one cycle after stall_req drops.
module npc_ctrl #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] EXC_VEC  = cpu_defs::EXC_VEC,
  parameter logic [31:0] PC_MAX   = cpu_defs::PC_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall_req,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  output logic [31:0] next_pc,
  output logic        pc_stall,
  output logic        flush_d,
  output logic        redirect_pending,
  output logic        fetch_adel,
  output logic [31:0] redirect_cnt
);

  import cpu_defs::*;

  npc_state_e  state_q, state_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic        redirect;
  logic        force_redirect;

  assign force_redirect = exc_valid | eret_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pend_target_q  <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pend_target_q  <= pend_target_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    if (force_redirect) begin
      state_d       = ST_IDLE;
      pend_target_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (br_valid && stall_req) begin
            state_d       = ST_PEND;
            pend_target_d = br_target;
          end
        end
        ST_PEND: begin
          // A further branch during the stall is dropped; the first one wins.
          if (!stall_req) begin
            state_d       = ST_IDLE;
            pend_target_d = '0;
          end
        end
        default: begin
          state_d       = ST_IDLE;
          pend_target_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    next_pc  = pc + 32'd4;
    redirect = 1'b1;
    if (exc_valid) begin
      next_pc = EXC_VEC;
    end else if (eret_valid) begin
      next_pc = epc;
    end else if (state_q == ST_PEND) begin
      next_pc = pend_target_q;
    end else if (br_valid) begin
      next_pc = br_target;
    end else begin
      redirect = 1'b0;
    end
  end

  assign pc_stall         = stall_req & ~force_redirect;
  assign flush_d          = force_redirect;
  assign redirect_pending = (state_q == ST_PEND);
  assign fetch_adel       = (pc[1:0] != 2'b00) | (pc < RESET_PC) | (pc > PC_MAX);

  // Only redirects the PC register actually takes are counted; wraps naturally.
  assign redirect_cnt_d = redirect_cnt_q + {31'd0, redirect & ~pc_stall};
  assign redirect_cnt   = redirect_cnt_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed bench for npc_ctrl: expected outputs queued per step, popped and compared mid-cycle.
module tb_npc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        stall_req;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic [31:0] next_pc;
  logic        pc_stall;
  logic        flush_d;
  logic        redirect_pending;
  logic        fetch_adel;
  logic [31:0] redirect_cnt;

  typedef struct {
    string       name;
    logic [31:0] np;
    logic        stall;
    logic        flush;
    logic        pend;
    logic        adel;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  npc_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .pc               (pc),
    .stall_req        (stall_req),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .exc_valid        (exc_valid),
    .eret_valid       (eret_valid),
    .epc              (epc),
    .next_pc          (next_pc),
    .pc_stall         (pc_stall),
    .flush_d          (flush_d),
    .redirect_pending (redirect_pending),
    .fetch_adel       (fetch_adel),
    .redirect_cnt     (redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [31:0] e_np, input logic e_stall,
                          input logic e_flush, input logic e_pend, input logic e_adel,
                          input logic [31:0] e_cnt);
    exp_t e;
    e.name  = name;
    e.np    = e_np;
    e.stall = e_stall;
    e.flush = e_flush;
    e.pend  = e_pend;
    e.adel  = e_adel;
    e.cnt   = e_cnt;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_vec++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, ".next_pc"},          next_pc,          e.np);
      chk({e.name, ".pc_stall"},         pc_stall,         e.stall);
      chk({e.name, ".flush_d"},          flush_d,          e.flush);
      chk({e.name, ".redirect_pending"}, redirect_pending, e.pend);
      chk({e.name, ".fetch_adel"},       fetch_adel,       e.adel);
      chk({e.name, ".redirect_cnt"},     redirect_cnt,     e.cnt);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then compare before the next rising edge.
  task automatic step(input string name, input logic [31:0] i_pc, input logic i_stall,
                      input logic i_br, input logic [31:0] i_brt, input logic i_exc,
                      input logic i_eret, input logic [31:0] i_epc,
                      input logic [31:0] e_np, input logic e_stall, input logic e_flush,
                      input logic e_pend, input logic e_adel, input logic [31:0] e_cnt);
    @(negedge clk);
    pc         = i_pc;
    stall_req  = i_stall;
    br_valid   = i_br;
    br_target  = i_brt;
    exc_valid  = i_exc;
    eret_valid = i_eret;
    epc        = i_epc;
    push_exp(name, e_np, e_stall, e_flush, e_pend, e_adel, e_cnt);
    #2;
    pop_check();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    pc         = 32'h3000;
    stall_req  = 1'b0;
    br_valid   = 1'b0;
    br_target  = 32'h0;
    exc_valid  = 1'b0;
    eret_valid = 1'b0;
    epc        = 32'h0;

    // Reset state, held across a rising edge.
    step("reset", 32'h3000, 0, 0, 32'h0, 0, 0, 32'h0, 32'h3004, 0, 0, 0, 0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //   name          pc          st br brt          ex er epc          np           st fl pd ad cnt
    step("seq",        32'h3000,   0, 0, 32'h0,       0, 0, 32'h0,       32'h3004,    0, 0, 0, 0, 32'd0);
    step("br_stall1",  32'h3004,   1, 1, 32'h3100,    0, 0, 32'h0,       32'h3100,    1, 0, 0, 0, 32'd0);
    step("pend_hold",  32'h3004,   1, 0, 32'h0,       0, 0, 32'h0,       32'h3100,    1, 0, 1, 0, 32'd0);
    step("pend_newbr", 32'h3004,   1, 1, 32'h3300,    0, 0, 32'h0,       32'h3100,    1, 0, 1, 0, 32'd0);
    step("pend_rel",   32'h3004,   0, 0, 32'h0,       0, 0, 32'h0,       32'h3100,    0, 0, 1, 0, 32'd0);
    step("after_rel",  32'h3100,   0, 0, 32'h0,       0, 0, 32'h0,       32'h3104,    0, 0, 0, 0, 32'd1);
    step("br_nostall", 32'h3104,   0, 1, 32'h3400,    0, 0, 32'h0,       32'h3400,    0, 0, 0, 0, 32'd1);
    step("after_br",   32'h3400,   0, 0, 32'h0,       0, 0, 32'h0,       32'h3404,    0, 0, 0, 0, 32'd2);
    step("br_stall2",  32'h3404,   1, 1, 32'h3100,    0, 0, 32'h0,       32'h3100,    1, 0, 0, 0, 32'd2);
    step("exc_pend",   32'h3404,   1, 0, 32'h0,       1, 0, 32'h0,       32'h4180,    0, 1, 1, 0, 32'd2);
    step("after_exc",  32'h4180,   0, 0, 32'h0,       0, 0, 32'h0,       32'h4184,    0, 0, 0, 0, 32'd3);
    step("prio_all",   32'h4184,   0, 1, 32'h3300,    1, 1, 32'h3200,    32'h4180,    0, 1, 0, 0, 32'd3);
    step("prio_eret",  32'h4180,   0, 1, 32'h3300,    0, 1, 32'h3200,    32'h3200,    0, 1, 0, 0, 32'd4);
    step("eret_stall", 32'h3200,   1, 0, 32'h0,       0, 1, 32'h3208,    32'h3208,    0, 1, 0, 0, 32'd5);
    step("rng_mis",    32'h3002,   0, 0, 32'h0,       0, 0, 32'h0,       32'h3006,    0, 0, 0, 1, 32'd6);
    step("rng_hi",     32'h7000,   0, 0, 32'h0,       0, 0, 32'h0,       32'h7004,    0, 0, 0, 1, 32'd6);
    step("rng_max",    32'h6FFC,   0, 0, 32'h0,       0, 0, 32'h0,       32'h7000,    0, 0, 0, 0, 32'd6);
    step("rng_lo",     32'h2FFC,   0, 0, 32'h0,       0, 0, 32'h0,       32'h3000,    0, 0, 0, 1, 32'd6);
    step("rng_base",   32'h3000,   0, 0, 32'h0,       0, 0, 32'h0,       32'h3004,    0, 0, 0, 0, 32'd6);
    step("pc_wrap",    32'hFFFFFFFC, 0, 0, 32'h0,     0, 0, 32'h0,       32'h0,       0, 0, 0, 1, 32'd6);

    // Enter PEND again, then hit reset between clock edges.
    step("br_stall3",  32'h3000,   1, 1, 32'h3100,    0, 0, 32'h0,       32'h3100,    1, 0, 0, 0, 32'd6);
    step("pend_pre",   32'h3000,   1, 0, 32'h0,       0, 0, 32'h0,       32'h3100,    1, 0, 1, 0, 32'd6);
    #1;
    reset = 1'b1;
    push_exp("async_rst", 32'h3004, 1, 0, 0, 0, 32'd0);
    #1;
    pop_check();
    @(negedge clk);
    reset = 1'b0;
    step("post_rst",   32'h3000,   0, 0, 32'h0,       0, 0, 32'h0,       32'h3004,    0, 0, 0, 0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/npc_ctrl.md
NPC_CTRL -- requirements
Module: npc_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, first fetch address; also the lower bound of the legal fetch range.
REQ-002 Parameter EXC_VEC, 32'h0000_4180, exception handler entry address.
REQ-003 Parameter PC_MAX, 32'h0000_6FFC, highest legal fetch address.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 pc  in  32  current fetch PC from the PC register.
REQ-007 stall_req  in  1  hazard unit requests the fetch be frozen this cycle.
REQ-008 br_valid  in  1  one-cycle pulse: a taken branch/jump is resolved this cycle.
REQ-009 br_target  in  32  branch/jump target, qualified by br_valid.
REQ-010 exc_valid  in  1  exception/interrupt redirect this cycle.
REQ-011 eret_valid  in  1  eret redirect this cycle.
REQ-012 epc  in  32  return address, qualified by eret_valid.
REQ-013 next_pc  out  32  value the PC register loads when not stalled.
REQ-014 pc_stall  out  1  stall to the PC register.
REQ-015 flush_d  out  1  flush the IF/ID register.
REQ-016 redirect_pending  out  1  a buffered branch target is waiting.
REQ-017 fetch_adel  out  1  the current pc is misaligned or outside [RESET_PC, PC_MAX].
REQ-018 redirect_cnt  out  32  count of applied redirects.

Function
REQ-019 next_pc priority SHALL be, combinationally: exc_valid -> EXC_VEC; else eret_valid -> epc; else PEND state -> pend_target; else br_valid -> br_target; else pc+4 (mod 2^32).
REQ-020 pc_stall SHALL equal stall_req & ~exc_valid & ~eret_valid.
REQ-021 flush_d SHALL equal exc_valid | eret_valid.
REQ-022 The FSM SHALL have two states: IDLE and PEND.
REQ-023 IDLE -> PEND SHALL occur when br_valid & stall_req & ~exc_valid & ~eret_valid; pend_target captures br_target on that edge.
REQ-024 In PEND with stall_req=1 and no exc_valid/eret_valid, the FSM SHALL stay in PEND and hold pend_target; a new br_valid SHALL be ignored.
REQ-025 In PEND with stall_req=0, next_pc SHALL be pend_target, and the FSM SHALL return to IDLE on the next edge (one-cycle release latency).
REQ-026 exc_valid or eret_valid in any state SHALL force IDLE on the next edge and discard pend_target.
REQ-027 redirect_pending SHALL equal (state==PEND).
REQ-028 fetch_adel SHALL equal (pc[1:0]!=0) | (pc<RESET_PC) | (pc>PC_MAX), using unsigned compares.
REQ-029 redirect_cnt SHALL increment by 1 on each edge where ~pc_stall and next_pc is selected from EXC_VEC, epc, pend_target or br_target; it SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 br_valid while stalled and in IDLE SHALL NOT count until the buffered redirect is applied.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE, pend_target=0 and redirect_cnt=0, including mid-PEND.
REQ-032 During reset, outputs SHALL follow REQ-019 to REQ-021, REQ-027 and REQ-028 from the reset state: redirect_pending=0, redirect_cnt=0.

Structure
REQ-033 RESET_PC, EXC_VEC, PC_MAX and the IDLE/PEND state encoding SHALL live in the shared cpu_defs package.
REQ-034 The block SHALL be flat, with no sub-modules; the pc+4 adder and range comparators are inline.

Verification
REQ-035 Sequential fetch: pc=0x3000, no requests -> next_pc=0x3004, pc_stall=0, redirect_cnt unchanged.
REQ-036 Branch while stalled: br_valid with br_target=0x3100 and stall_req=1 for 3 cycles -> PEND, redirect_pending=1, pc_stall=1; stall drops -> next_pc=0x3100 for one cycle, then IDLE, and redirect_cnt is +1.
REQ-037 Exception over pending: in PEND (target 0x3100) assert exc_valid with stall_req=1 -> next_pc=0x4180, pc_stall=0, flush_d=1, next state IDLE, redirect_pending=0.
REQ-038 Priority: exc_valid, eret_valid (epc=0x3200) and br_valid (0x3300) together -> next_pc=0x4180; drop exc_valid -> next_pc=0x3200.
REQ-039 Range: pc=0x3002 -> fetch_adel=1; pc=0x7000 -> fetch_adel=1; pc=0x6FFC -> fetch_adel=0.
REQ-040 Async reset mid-PEND: assert reset between clock edges -> redirect_pending=0 and redirect_cnt=0 before the next posedge.
